// File: rtl/i8253_pit.sv
// rtl/i8253_pit.sv - three-channel binary interval timer (8253/8254 subset)

// One counter channel: control/count/latch state, tick-driven counting, output shaping
module i8253_pit_channel (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       gate_i,
    input  logic       ctrl_wr_i,
    input  logic       latch_i,
    input  logic       cnt_wr_i,
    input  logic       rd_i,
    input  logic [7:0] data_i,
    output logic [7:0] rd_data_o,
    output logic       out_o
);

    // Mode encoding: 2'b00 = mode 0, 2'b10 = mode 2, 2'b11 = mode 3
    logic [16:0] count_q, count_d;
    logic [16:0] eff_q, eff_d;
    logic [15:0] n_q, n_d;
    logic [15:0] latch_q, latch_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  rw_q, rw_d;
    logic        armed_q, armed_d;
    logic        pend_q, pend_d;
    logic        wr_ff_q, wr_ff_d;
    logic        rd_ff_q, rd_ff_d;
    logic        latch_v_q, latch_v_d;
    logic        out_q, out_d;
    logic        gate_q;

    logic        gate_rise;
    logic        fin;
    logic [15:0] n_new;
    logic [15:0] rd_val;

    // Reload value actually counted: 0 stands for 65536, and 1 is too short for modes 2/3
    function automatic logic [16:0] eff_of(input logic [15:0] n, input logic [1:0] m);
        if (n == 16'd0)
            return 17'h10000;
        else if ((m != 2'b00) && (n == 16'd1))
            return 17'd2;
        else
            return {1'b0, n};
    endfunction

    assign gate_rise = gate_i & ~gate_q;

    // Next state: tick against pre-write state first, then reads, then writes override
    always_comb begin
        count_d   = count_q;
        eff_d     = eff_q;
        n_d       = n_q;
        latch_d   = latch_q;
        lsb_d     = lsb_q;
        mode_d    = mode_q;
        rw_d      = rw_q;
        armed_d   = armed_q;
        pend_d    = pend_q;
        wr_ff_d   = wr_ff_q;
        rd_ff_d   = rd_ff_q;
        latch_v_d = latch_v_q;
        out_d     = out_q;
        fin       = 1'b0;
        n_new     = n_q;

        if ((mode_q != 2'b00) && gate_rise && armed_q)
            pend_d = 1'b1;

        if (tick_i) begin
            if (pend_q && gate_i) begin
                count_d = eff_of(n_q, mode_q);
                eff_d   = eff_of(n_q, mode_q);
                armed_d = 1'b1;
                pend_d  = 1'b0;
            end else if (armed_q && gate_i) begin
                if (mode_q == 2'b00) begin
                    count_d = (count_q == 17'd0) ? 17'h0FFFF : count_q - 17'd1;
                    if (count_q == 17'd1)
                        out_d = 1'b1;
                end else if (count_q <= 17'd1) begin
                    count_d = eff_of(n_q, mode_q);
                    eff_d   = eff_of(n_q, mode_q);
                end else begin
                    count_d = count_q - 17'd1;
                end
            end
        end

        if (rd_i) begin
            if (rw_q == 2'b11)
                rd_ff_d = ~rd_ff_q;
            if (latch_v_q && ((rw_q != 2'b11) || rd_ff_q))
                latch_v_d = 1'b0;
        end

        if (latch_i && !latch_v_q) begin
            latch_d   = count_q[15:0];
            latch_v_d = 1'b1;
        end

        if (ctrl_wr_i) begin
            mode_d  = data_i[2] ? {1'b1, data_i[1]} : 2'b00;
            rw_d    = data_i[5:4];
            armed_d = 1'b0;
            pend_d  = 1'b0;
            wr_ff_d = 1'b0;
            rd_ff_d = 1'b0;
            out_d   = data_i[2];
        end

        if (cnt_wr_i) begin
            case (rw_q)
                2'b01: begin
                    n_new = {8'h00, data_i};
                    fin   = 1'b1;
                end
                2'b10: begin
                    n_new = {data_i, 8'h00};
                    fin   = 1'b1;
                end
                2'b11: begin
                    if (!wr_ff_q) begin
                        lsb_d   = data_i;
                        wr_ff_d = 1'b1;
                    end else begin
                        n_new   = {data_i, lsb_q};
                        fin     = 1'b1;
                        wr_ff_d = 1'b0;
                    end
                end
                default: ;
            endcase
            if (fin) begin
                n_d = n_new;
                if (mode_q == 2'b00) begin
                    pend_d = 1'b1;
                    out_d  = 1'b0;
                end else if (!armed_q) begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= 17'd0;
            eff_q     <= 17'd0;
            n_q       <= 16'd0;
            latch_q   <= 16'd0;
            lsb_q     <= 8'd0;
            mode_q    <= 2'b00;
            rw_q      <= 2'b11;
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
            wr_ff_q   <= 1'b0;
            rd_ff_q   <= 1'b0;
            latch_v_q <= 1'b0;
            out_q     <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            eff_q     <= eff_d;
            n_q       <= n_d;
            latch_q   <= latch_d;
            lsb_q     <= lsb_d;
            mode_q    <= mode_d;
            rw_q      <= rw_d;
            armed_q   <= armed_d;
            pend_q    <= pend_d;
            wr_ff_q   <= wr_ff_d;
            rd_ff_q   <= rd_ff_d;
            latch_v_q <= latch_v_d;
            out_q     <= out_d;
            gate_q    <= gate_i;
        end
    end

    // Read byte: latched snapshot if held, else live count; 65536 truncates to 0
    always_comb begin
        rd_val = latch_v_q ? latch_q : count_q[15:0];
        case (rw_q)
            2'b01:   rd_data_o = rd_val[7:0];
            2'b10:   rd_data_o = rd_val[15:8];
            default: rd_data_o = rd_ff_q ? rd_val[15:8] : rd_val[7:0];
        endcase
    end

    // Output: mode 0 is a registered terminal-count flag, modes 2/3 decode the count
    always_comb begin
        if (mode_q == 2'b00)
            out_o = out_q;
        else if (!armed_q || !gate_i)
            out_o = 1'b1;
        else if (mode_q == 2'b10)
            out_o = (count_q != 17'd1);
        else
            out_o = (count_q > (eff_q >> 1));
    end

endmodule

// Top: address decode to three channels and read-data mux
module i8253_pit #(
    parameter int unsigned NUM_CH = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_i,
    input  logic       rd_i,
    input  logic [1:0] a_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    input  logic       tick_i,
    input  logic [2:0] gate_i,
    output logic [2:0] out_o
);

    logic [7:0] rd_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ctrl_hit;
        assign ctrl_hit = wr_i && (a_i == 2'd3) && (data_i[7:6] == 2'(g));

        i8253_pit_channel u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .tick_i    (tick_i),
            .gate_i    (gate_i[g]),
            .ctrl_wr_i (ctrl_hit && (data_i[5:4] != 2'b00)),
            .latch_i   (ctrl_hit && (data_i[5:4] == 2'b00)),
            .cnt_wr_i  (wr_i && (a_i == 2'(g))),
            .rd_i      (rd_i && !wr_i && (a_i == 2'(g))),
            .data_i    (data_i),
            .rd_data_o (rd_data[g]),
            .out_o     (out_o[g])
        );
    end

    // Read mux; the control-word address reads back as zero
    always_comb begin
        data_o = 8'h00;
        case (a_i)
            2'd0:    data_o = rd_data[0];
            2'd1:    data_o = rd_data[1];
            2'd2:    data_o = rd_data[2];
            default: data_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_i8253_pit.sv
// tb/tb_i8253_pit.sv - directed self-checking bench for i8253_pit
module tb_i8253_pit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_i = 1'b0;
    logic       rd_i = 1'b0;
    logic [1:0] a_i = 2'd0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       tick_i = 1'b0;
    logic [2:0] gate_i = 3'b111;
    logic [2:0] out_o;

    int n_tests = 0;
    int n_fail  = 0;

    i8253_pit dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_i   (wr_i),
        .rd_i   (rd_i),
        .a_i    (a_i),
        .data_i (data_i),
        .data_o (data_o),
        .tick_i (tick_i),
        .gate_i (gate_i),
        .out_o  (out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        a_i = a; data_i = d; wr_i = 1'b1;
        cycle();
        wr_i = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        a_i = a; rd_i = 1'b1;
        cycle();
        rd_i = 1'b0;
    endtask

    task automatic tkn(input int n);
        tick_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
        tick_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out", 16'(out_o), 16'h0);
        chk("rst_data", 16'(data_o), 16'h0);
        cycle(); cycle();
        rst_i = 1'b0;
        cycle();
        chk("rst_out_rel", 16'(out_o), 16'h0);

        // Ch0 mode 3, N=4: 1,1,0,0 repeating after the load tick
        wr(2'd3, 8'h36); wr(2'd0, 8'h04); wr(2'd0, 8'h00);
        chk("m3_armwait_out", 16'(out_o[0]), 16'h1);
        for (int k = 0; k < 8; k++) begin
            tkn(1);
            chk($sformatf("m3_n4_k%0d", k), 16'(out_o[0]), 16'((k % 4) < 2));
        end
        a_i = 2'd0; #1;
        chk("m3_live_cnt", 16'(data_o), 16'h01);
        a_i = 2'd3; #1;
        chk("ctrl_addr_read", 16'(data_o), 16'h00);

        // Ch1 mode 2, N=3: 1,1,0 repeating
        wr(2'd3, 8'h74); wr(2'd1, 8'h03); wr(2'd1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            tkn(1);
            chk($sformatf("m2_n3_k%0d", k), 16'(out_o[1]), 16'((k % 3) != 2));
        end

        // Ch2 mode 0, N=5: out rises on 5th tick after load
        wr(2'd3, 8'hB0);
        chk("m0_ctrl_out", 16'(out_o[2]), 16'h0);
        wr(2'd2, 8'h05); wr(2'd2, 8'h00);
        tkn(1);
        for (int k = 1; k <= 5; k++) begin
            tkn(1);
            chk($sformatf("m0_n5_t%0d", k), 16'(out_o[2]), 16'(k == 5));
        end
        // Rewrite restarts; gate low for 2 ticks delays the rise by 2
        wr(2'd2, 8'h05); wr(2'd2, 8'h00);
        chk("m0_restart_out", 16'(out_o[2]), 16'h0);
        tkn(1); tkn(2);
        gate_i[2] = 1'b0;
        tkn(2);
        a_i = 2'd2; #1;
        chk("m0_frozen_cnt", 16'(data_o), 16'h03);
        gate_i[2] = 1'b1;
        tkn(2);
        chk("m0_gate_t6", 16'(out_o[2]), 16'h0);
        tkn(1);
        chk("m0_gate_t7", 16'(out_o[2]), 16'h1);

        // Ch0 latch: N=10, latch at 6, read 06,00 then live 03
        wr(2'd3, 8'h34); wr(2'd0, 8'h0A); wr(2'd0, 8'h00);
        tkn(1); tkn(4);
        wr(2'd3, 8'h00);
        tkn(3);
        a_i = 2'd0; #1;
        chk("latch_lsb", 16'(data_o), 16'h06);
        rd(2'd0);
        chk("latch_msb", 16'(data_o), 16'h00);
        rd(2'd0);
        chk("live_after_latch", 16'(data_o), 16'h03);
        rd(2'd0);
        chk("live_msb", 16'(data_o), 16'h00);
        rd(2'd0);
        // Second latch while valid is ignored
        wr(2'd3, 8'h00);
        tkn(1);
        wr(2'd3, 8'h00);
        tkn(1);
        a_i = 2'd0; #1;
        chk("latch_second_ignored", 16'(data_o), 16'h03);
        rd(2'd0); rd(2'd0);

        // Ch1 mode 3, N=5: 3 high, 2 low; gate low forces 1; gate rise restarts
        wr(2'd3, 8'h76); wr(2'd1, 8'h05); wr(2'd1, 8'h00);
        for (int k = 0; k < 9; k++) begin
            tkn(1);
            chk($sformatf("m3_n5_k%0d", k), 16'(out_o[1]), 16'((k % 5) < 3));
        end
        gate_i[1] = 1'b0; #1;
        chk("m3_gate_low_out", 16'(out_o[1]), 16'h1);
        tkn(2);
        chk("m3_gate_low_held", 16'(out_o[1]), 16'h1);
        gate_i[1] = 1'b1;
        cycle();
        for (int k = 0; k < 5; k++) begin
            tkn(1);
            chk($sformatf("m3_restart_k%0d", k), 16'(out_o[1]), 16'(k < 3));
        end

        // Ch0 mode 0, N=0 -> 65536 ticks
        wr(2'd3, 8'h30); wr(2'd0, 8'h00); wr(2'd0, 8'h00);
        tkn(1);
        tkn(65535);
        chk("m0_65535_out", 16'(out_o[0]), 16'h0);
        a_i = 2'd0; #1;
        chk("m0_65535_cnt", 16'(data_o), 16'h01);
        tkn(1);
        chk("m0_65536_out", 16'(out_o[0]), 16'h1);

        // Restart, then reset mid-count
        wr(2'd0, 8'h00); wr(2'd0, 8'h00);
        chk("m0_rewrite_out", 16'(out_o[0]), 16'h0);
        tkn(1);
        a_i = 2'd0; #1;
        chk("m0_65536_reads0", 16'(data_o), 16'h00);
        tkn(100);
        chk("m0_cnt_after100", 16'(data_o), 16'h9C);
        #2;
        rst_i = 1'b1; #1;
        chk("async_rst_out", 16'(out_o), 16'h0);
        chk("async_rst_data", 16'(data_o), 16'h00);
        cycle();
        rst_i = 1'b0;
        tkn(10);
        chk("post_rst_out", 16'(out_o), 16'h0);
        a_i = 2'd0; #1;
        chk("post_rst_cnt", 16'(data_o), 16'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
